spi_flash_loader: RTL and testbench
===================================

# spi_flash_loader

Wishbone-master sequencer that sits directly upstream of the team's Wishbone SPI master controller. It drives the controller's register interface to read a block of an SPI flash with the standard READ command (0x03). It packs the received bytes into 32-bit words and presents them on a valid/ready stream for a downstream memory writer, for example a boot loader or a bitmap fetcher.

## Interface
- SPI_BASE, 32'h0000_0000, Wishbone base address of the SPI controller
- SCK_DIV, 8'd3, value written to the controller's divisor register before each transfer
- READ_CMD, 8'h03, flash read opcode
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- flash_addr  in  24  flash byte address, latched on accepted start
- word_count  in  16  number of 32-bit words to fetch, latched on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of job
- m_adr_o  out  32  Wishbone address
- m_dat_o  out  32  Wishbone write data
- m_dat_i  in  32  Wishbone read data
- m_sel_o  out  4  fixed 4'b1111
- m_cyc_o, m_stb_o, m_we_o  out  1 each  Wishbone controls; cyc equals stb
- m_ack_i  in  1  Wishbone acknowledge
- out_data  out  32  packed word; first flash byte in [7:0], little-endian
- out_valid  out  1  word available
- out_ready  in  1  consumer accepts word when valid and ready

## Operation
- Controller register map, as byte offsets from SPI_BASE:
  - 0x00 DATA: a write loads the shift byte and starts the transfer; a read returns the received byte in [7:0].
  - 0x04 STATUS: bit0 = running.
  - 0x08 CS: bit0 drives the chip select, active-low.
  - 0x10 DIV: the clock divisor.
- States and transitions:
  - IDLE → on start with word_count≠0 → DIV.
  - On start with word_count=0: done pulses the next cycle; no bus traffic occurs.
  - DIV: write SCK_DIV to DIV.
  - CSLO: write 0 to CS.
  - SEND: write the next transmit byte to DATA.
  - POLL: read STATUS; repeat POLL until bit0=0.
  - FETCH: read DATA. This state is skipped for the 4 header bytes.
  - EMIT: raise out_valid and hold until out_ready.
  - CSHI: write 1 to CS.
  - FIN: pulse done → IDLE.
- Byte sequence:
  - Header: READ_CMD, addr[23:16], addr[15:8], addr[7:0]. Received bytes are discarded.
  - Then 4×word_count data bytes. The transmit byte is 0x00 and each received byte is shifted into the packer.
- After every 4th data byte the path goes to EMIT, and after EMIT returns to SEND. After the last EMIT the path goes to CSHI.
- Byte counter is 18 bits and word counter is 16 bits; both count up and must not wrap. The counters are compared against the latched word_count.
- CS stays low during out_ready backpressure. Pausing SCK between bytes is legal for the flash.
- start while busy is ignored.
- The block issues no retry or timeout. POLL loops indefinitely while the controller reports running.

## Timing
- Reset values:
  - busy=0, done=0, out_valid=0, m_cyc_o=m_stb_o=m_we_o=0, m_adr_o=0, m_dat_o=0, out_data=0.
  - State = IDLE.
- Each Wishbone access:
  - adr, dat, we, cyc and stb are asserted together and held stable until the cycle m_ack_i is seen high.
  - Those signals drop on the following edge.
  - At least one idle cycle separates accesses.
  - With the controller's 1-cycle ack, an access costs 3 clocks.
- Read data is captured on the edge where m_ack_i=1.
- out_valid rises on the cycle after the 4th byte's FETCH ack.
- out_data is stable while out_valid is high and out_valid&~out_ready holds.
- busy rises the cycle after the accepted start. busy falls in the same cycle done pulses.
- Reset mid-job:
  - The bus is released immediately.
  - CS is not re-written. Software, or the next job's CSLO, restores a defined CS level.

## Structure
- The shared package holds:
  - Register offsets DATA/STATUS/CS/DIV.
  - The state enum.
  - The flash opcode constants.
- One sub-module, spi_wb_access: a single-transaction Wishbone master with inputs req/we/adr/wdat and outputs rdat/ack_pulse. The sequencer FSM calls it.

## Test plan
- Basic fetch: flash model holds 0x11,0x22,0x33,0x44 at 0x000100; start with addr=0x000100, count=1 → bus writes DIV=3, CS=0, then DATA 0x03,0x00,0x01,0x00, then 4 dummy reads; out_data=0x44332211; CS=1; one done pulse.
- Zero count: word_count=0 → done one cycle after start; m_cyc_o never asserts.
- Backpressure: count=3 with out_ready held low for 20 cycles at word 2 → no Wishbone traffic during the stall; all 3 words are correct and in order; CS stays low throughout.
- Poll loop: controller model reports running for 50 reads → FSM keeps issuing STATUS reads, then FETCH; the byte is correct.
- Start while busy: second start mid-job with a different address → ignored; the first job's data is unchanged.
- Reset mid-job: reset asserted in word 2 → next cycle cyc=stb=0, busy=0, out_valid=0; a new job then completes correctly.

Source files
------------

// File: rtl/spi_flash_loader_pkg.sv
// Shared definitions for the SPI flash loader: controller register map,
// flash opcode and the sequencer state encoding.
package spi_flash_loader_pkg;

    // Byte offsets of the SPI master controller registers.
    localparam logic [7:0] REG_DATA   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h04;
    localparam logic [7:0] REG_CS     = 8'h08;
    localparam logic [7:0] REG_DIV    = 8'h10;

    localparam logic [7:0] FLASH_READ = 8'h03;
    localparam logic [7:0] DUMMY_TX   = 8'h00;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DIV,
        ST_CSLO,
        ST_SEND,
        ST_POLL,
        ST_FETCH,
        ST_EMIT,
        ST_CSHI,
        ST_FIN
    } state_t;

    function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [7:0] off);
        return base + {24'h0, off};
    endfunction

endpackage

// File: rtl/spi_wb_access.sv
// Single-transaction Wishbone master: launches one access when req is seen
// while the bus is idle and reports completion with a one-cycle ack_pulse.
module spi_wb_access (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wdat,
    output logic [31:0] rdat,
    output logic        ack_pulse,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic [3:0]  m_sel_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    input  logic        m_ack_i
);

    logic cyc_q;

    // The cycle after an ack always sees cyc_q low, so at least one idle
    // cycle separates accesses even when req stays high back-to-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q   <= 1'b0;
            m_we_o  <= 1'b0;
            m_adr_o <= 32'h0;
            m_dat_o <= 32'h0;
        end else if (cyc_q) begin
            if (m_ack_i) begin
                cyc_q  <= 1'b0;
                m_we_o <= 1'b0;
            end
        end else if (req) begin
            cyc_q   <= 1'b1;
            m_we_o  <= we;
            m_adr_o <= adr;
            m_dat_o <= we ? wdat : 32'h0;
        end
    end

    assign m_cyc_o   = cyc_q;
    assign m_stb_o   = cyc_q;
    assign m_sel_o   = 4'b1111;
    assign ack_pulse = cyc_q & m_ack_i;
    assign rdat      = m_dat_i;

endmodule

// File: rtl/spi_flash_loader.sv
// Sequencer that reads a block of SPI flash through the Wishbone SPI master
// controller and streams the bytes out as little-endian 32-bit words.
module spi_flash_loader
    import spi_flash_loader_pkg::*;
#(
    parameter logic [31:0] SPI_BASE = 32'h0000_0000,
    parameter logic [7:0]  SCK_DIV  = 8'd3,
    parameter logic [7:0]  READ_CMD = FLASH_READ
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] flash_addr,
    input  logic [15:0] word_count,
    output logic        busy,
    output logic        done,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic [3:0]  m_sel_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    input  logic        m_ack_i,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output state_t      state_dbg
);

    state_t      state;
    logic [23:0] addr_q;
    logic [15:0] wc_q;
    logic [15:0] word_cnt;
    logic [17:0] byte_cnt;
    logic [1:0]  hdr_idx;
    logic        in_hdr;
    logic [23:0] pack;

    logic        acc_req;
    logic        acc_we;
    logic [7:0]  acc_off;
    logic [31:0] acc_wdat;
    logic [31:0] acc_rdat;
    logic        acc_ack;
    logic [7:0]  tx_byte;
    logic        last_word;
    logic        unused_rdat_hi;

    spi_wb_access u_access (
        .clk       (clk),
        .reset     (reset),
        .req       (acc_req),
        .we        (acc_we),
        .adr       (reg_addr(SPI_BASE, acc_off)),
        .wdat      (acc_wdat),
        .rdat      (acc_rdat),
        .ack_pulse (acc_ack),
        .m_adr_o   (m_adr_o),
        .m_dat_o   (m_dat_o),
        .m_dat_i   (m_dat_i),
        .m_sel_o   (m_sel_o),
        .m_cyc_o   (m_cyc_o),
        .m_stb_o   (m_stb_o),
        .m_we_o    (m_we_o),
        .m_ack_i   (m_ack_i)
    );

    // The controller only drives a byte onto DATA[7:0] and STATUS[0].
    assign unused_rdat_hi = ^acc_rdat[31:8];

    always_comb begin
        tx_byte = DUMMY_TX;
        if (in_hdr) begin
            case (hdr_idx)
                2'd0:    tx_byte = READ_CMD;
                2'd1:    tx_byte = addr_q[23:16];
                2'd2:    tx_byte = addr_q[15:8];
                default: tx_byte = addr_q[7:0];
            endcase
        end
    end

    // Each bus-facing state names exactly one register access; req is held
    // for the whole state and the access block retires it with acc_ack.
    always_comb begin
        acc_req  = 1'b0;
        acc_we   = 1'b0;
        acc_off  = REG_DATA;
        acc_wdat = 32'h0;
        case (state)
            ST_DIV: begin
                acc_req  = 1'b1;
                acc_we   = 1'b1;
                acc_off  = REG_DIV;
                acc_wdat = {24'h0, SCK_DIV};
            end
            ST_CSLO: begin
                acc_req  = 1'b1;
                acc_we   = 1'b1;
                acc_off  = REG_CS;
                acc_wdat = 32'h0;
            end
            ST_SEND: begin
                acc_req  = 1'b1;
                acc_we   = 1'b1;
                acc_off  = REG_DATA;
                acc_wdat = {24'h0, tx_byte};
            end
            ST_POLL: begin
                acc_req  = 1'b1;
                acc_off  = REG_STATUS;
            end
            ST_FETCH: begin
                acc_req  = 1'b1;
                acc_off  = REG_DATA;
            end
            ST_CSHI: begin
                acc_req  = 1'b1;
                acc_we   = 1'b1;
                acc_off  = REG_CS;
                acc_wdat = 32'h1;
            end
            default: ;
        endcase
    end

    assign last_word = ({1'b0, word_cnt} + 17'd1) == {1'b0, wc_q};

    // Output stream: a word transfers on any edge where out_valid and
    // out_ready are both high; once raised, out_valid and out_data hold
    // unchanged until that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 32'h0;
            addr_q    <= 24'h0;
            wc_q      <= 16'h0;
            word_cnt  <= 16'h0;
            byte_cnt  <= 18'h0;
            hdr_idx   <= 2'd0;
            in_hdr    <= 1'b0;
            pack      <= 24'h0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr_q   <= flash_addr;
                        wc_q     <= word_count;
                        word_cnt <= 16'h0;
                        byte_cnt <= 18'h0;
                        hdr_idx  <= 2'd0;
                        in_hdr   <= 1'b1;
                        if (word_count == 16'h0) begin
                            done <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    if (acc_ack) state <= ST_CSLO;
                end
                ST_CSLO: begin
                    if (acc_ack) state <= ST_SEND;
                end
                ST_SEND: begin
                    if (acc_ack) state <= ST_POLL;
                end
                ST_POLL: begin
                    if (acc_ack && !acc_rdat[0]) begin
                        if (in_hdr) begin
                            // Header replies are meaningless; go straight to the next byte.
                            hdr_idx <= hdr_idx + 2'd1;
                            if (hdr_idx == 2'd3) in_hdr <= 1'b0;
                            state <= ST_SEND;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (acc_ack) begin
                        byte_cnt <= byte_cnt + 18'd1;
                        if (byte_cnt[1:0] == 2'd3) begin
                            out_data  <= {acc_rdat[7:0], pack};
                            out_valid <= 1'b1;
                            state     <= ST_EMIT;
                        end else begin
                            pack  <= {acc_rdat[7:0], pack[23:8]};
                            state <= ST_SEND;
                        end
                    end
                end
                ST_EMIT: begin
                    // CS stays low while the consumer stalls; SCK simply pauses.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        word_cnt  <= word_cnt + 16'd1;
                        state     <= last_word ? ST_CSHI : ST_SEND;
                    end
                end
                ST_CSHI: begin
                    if (acc_ack) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_spi_flash_loader.sv
// Bench for spi_flash_loader: SPI-controller/flash model on the Wishbone side,
// word scoreboard on the stream side, table of jobs plus reset corner cases.
module tb_spi_flash_loader;
    import spi_flash_loader_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [23:0] flash_addr = 24'h0;
    logic [15:0] word_count = 16'h0;
    logic        busy, done;
    logic [31:0] m_adr_o, m_dat_o;
    logic [31:0] m_dat_i = 32'h0;
    logic [3:0]  m_sel_o;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic        m_ack_i = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    state_t      state_dbg;

    spi_flash_loader dut (
        .clk(clk), .reset(reset), .start(start), .flash_addr(flash_addr),
        .word_count(word_count), .busy(busy), .done(done),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_sel_o(m_sel_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_ack_i(m_ack_i),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h11;
            24'h000101: return 8'h22;
            24'h000102: return 8'h33;
            24'h000103: return 8'h44;
            default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
        endcase
    endfunction

    // ---------------- SPI controller + flash model ----------------
    int          poll_n = 0;
    int          run_left = 0;
    int          idx = 0;
    logic [31:0] hdr_sh = 32'h0;
    logic [7:0]  rx_byte = 8'h0;
    logic        model_cs = 1'b1;
    logic [7:0]  model_div = 8'h0;

    always @(posedge clk) begin
        m_ack_i <= 1'b0;
        if (m_cyc_o && m_stb_o && !m_ack_i) begin
            m_ack_i <= 1'b1;
            m_dat_i <= 32'h0;
            if (m_we_o) begin
                case (m_adr_o[7:0])
                    REG_DATA: begin
                        if (idx < 4) begin
                            hdr_sh  <= {hdr_sh[23:0], m_dat_o[7:0]};
                            rx_byte <= 8'hEE;
                        end else begin
                            rx_byte <= flash_byte(hdr_sh[23:0] + 24'(idx - 4));
                        end
                        idx      <= idx + 1;
                        run_left <= poll_n;
                    end
                    REG_CS: begin
                        model_cs <= m_dat_o[0];
                        if (!m_dat_o[0]) idx <= 0;
                    end
                    REG_DIV: model_div <= m_dat_o[7:0];
                    default: ;
                endcase
            end else begin
                case (m_adr_o[7:0])
                    REG_STATUS: begin
                        m_dat_i <= {31'h0, run_left > 0};
                        if (run_left > 0) run_left <= run_left - 1;
                    end
                    REG_DATA: m_dat_i <= {24'hABCDEF, rx_byte};
                    default: ;
                endcase
            end
        end
    end

    // ---------------- bus monitor ----------------
    typedef struct packed {
        logic [7:0] off;
        logic [7:0] dat;
    } wr_t;
    wr_t wlog[$];
    int  acc_cnt = 0;
    bit  cyc_seen = 1'b0;

    always @(negedge clk) begin
        if (m_cyc_o) cyc_seen = 1'b1;
        if (m_cyc_o && m_ack_i) begin
            acc_cnt++;
            if (m_we_o) wlog.push_back({m_adr_o[7:0], m_dat_o[7:0]});
        end
    end

    // ---------------- stream consumer / scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;
    logic [31:0] held;
    int          words_popped = 0;
    int          stall_word = -1;
    int          stall_len = 0;
    int          stall_left = 0;
    bit          rand_ready = 1'b0;

    always @(negedge clk) begin
        if (!reset && out_valid && words_popped == stall_word && stall_left > 0) begin
            if (stall_left == stall_len) held = out_data;
            else check("stall_hold", out_data, held);
            out_ready = 1'b0;
            stall_left--;
            check("stall_no_bus", {31'h0, m_cyc_o}, 32'h0);
            check("stall_cs_low", {31'h0, model_cs}, 32'h0);
        end else begin
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got 0x%08h, expected none", out_data);
            end else begin
                exp_w = exp_q.pop_front();
                check("word", out_data, exp_w);
            end
            words_popped++;
        end
    end

    // ---------------- job table ----------------
    typedef struct {
        logic [23:0] addr;
        logic [15:0] count;
        int          poll;
        int          stall_word;
        int          stall_len;
        bit          rnd;
        int          intrude;
        int          exp_acc;
        bit          chk_wr;
    } job_t;

    job_t jobs[6];
    wr_t  exp_wr[11];

    task automatic push_words(input logic [23:0] a, input logic [15:0] cnt);
        logic [23:0] b;
        for (int k = 0; k < int'(cnt); k++) begin
            b = a + 24'(4 * k);
            exp_q.push_back({flash_byte(b + 24'd3), flash_byte(b + 24'd2),
                             flash_byte(b + 24'd1), flash_byte(b)});
        end
    endtask

    task automatic run_job(input job_t j);
        bit found;
        int i;
        poll_n       = j.poll;
        stall_word   = j.stall_word;
        stall_len    = j.stall_len;
        stall_left   = j.stall_len;
        rand_ready   = j.rnd;
        words_popped = 0;
        acc_cnt      = 0;
        cyc_seen     = 1'b0;
        wlog.delete();
        push_words(j.addr, j.count);
        @(negedge clk);
        start = 1'b1;
        flash_addr = j.addr;
        word_count = j.count;
        @(negedge clk);
        start = 1'b0;
        flash_addr = 24'($urandom);
        word_count = 16'($urandom);
        if (j.count != 16'd0) check("busy_rise", {31'h0, busy}, 32'h1);
        found = 1'b0;
        for (i = 0; i < 8000; i++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            if (i == j.intrude) begin
                start = 1'b1;
                flash_addr = 24'h000900;
                word_count = 16'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", {31'h0, found}, 32'h1);
        if (j.count == 16'd0) begin
            check("zero_done_latency", i, 0);
            check("zero_no_cyc", {31'h0, cyc_seen}, 32'h0);
        end else begin
            check("cs_high_end", {31'h0, model_cs}, 32'h1);
        end
        check("busy_at_done", {31'h0, busy}, 32'h0);
        check("acc_count", acc_cnt, j.exp_acc);
        check("queue_drained", exp_q.size(), 0);
        if (j.chk_wr) begin
            check("wr_count", wlog.size(), 11);
            for (int k = 0; k < 11 && k < wlog.size(); k++) begin
                check("wr_off", {24'h0, wlog[k].off}, {24'h0, exp_wr[k].off});
                check("wr_dat", {24'h0, wlog[k].dat}, {24'h0, exp_wr[k].dat});
            end
            check("div_value", {24'h0, model_div}, 32'd3);
        end
        @(negedge clk);
        check("done_one_cycle", {31'h0, done}, 32'h0);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        jobs[0] = '{24'h000100, 16'd1, 0, -1, 0,  1'b0, -1, 23,  1'b1};
        jobs[1] = '{24'h000200, 16'd3, 0,  1, 20, 1'b0, -1, 47,  1'b0};
        jobs[2] = '{24'h0ABCDE, 16'd1, 50, -1, 0, 1'b0, -1, 423, 1'b0};
        jobs[3] = '{24'hFFFFFC, 16'd2, 1, -1, 0,  1'b1, -1, 47,  1'b0};
        jobs[4] = '{24'h001000, 16'd0, 0, -1, 0,  1'b0, -1, 0,   1'b0};
        jobs[5] = '{24'h000300, 16'd2, 0, -1, 0,  1'b1, 30, 35,  1'b0};
        exp_wr = '{'{8'h10, 8'h03}, '{8'h08, 8'h00}, '{8'h00, 8'h03}, '{8'h00, 8'h00},
                   '{8'h00, 8'h01}, '{8'h00, 8'h00}, '{8'h00, 8'h00}, '{8'h00, 8'h00},
                   '{8'h00, 8'h00}, '{8'h00, 8'h00}, '{8'h08, 8'h01}};

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_ctrl", {29'h0, m_cyc_o, m_stb_o, m_we_o}, 32'h0);
        check("rst_adr", m_adr_o, 32'h0);
        check("rst_dat", m_dat_o, 32'h0);
        check("rst_out", out_data, 32'h0);
        check("rst_state", {28'h0, state_dbg}, {28'h0, ST_IDLE});
        check("sel_fixed", {28'h0, m_sel_o}, 32'hF);
        reset = 1'b0;

        for (int r = 0; r < 6; r++) begin
            run_job(jobs[r]);
            if (jobs[r].intrude >= 0) begin
                cyc_seen = 1'b0;
                repeat (20) @(negedge clk);
                check("intrude_ignored", {31'h0, cyc_seen | busy}, 32'h0);
            end
        end

        // Reset during the second word of a three-word job
        poll_n = 0;
        stall_word = -1;
        stall_left = 0;
        rand_ready = 1'b0;
        words_popped = 0;
        push_words(24'h000400, 16'd3);
        @(negedge clk);
        start = 1'b1;
        flash_addr = 24'h000400;
        word_count = 16'd3;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (words_popped < 1 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("midjob_first_word", words_popped, 1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_cyc_stb", {30'h0, m_cyc_o, m_stb_o}, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_valid", {31'h0, out_valid}, 32'h0);
        reset = 1'b0;
        exp_q.delete();
        run_job('{24'h000500, 16'd2, 0, -1, 0, 1'b0, -1, 35, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
